reflet_int_ctrl: RTL

Memory-mapped interrupt controller in front of the CPU interrupt unit. Collects 8 peripheral interrupt sources, synchronises them, latches edges into pending bits, and routes each enabled source onto one of the 4 prioritised `ext_int` lines. Software configures the block and claims sources through a small register window; a claim read returns the winning source and clears its edge pending bit.

---
 rtl/reflet_int_ctrl.sv | 120 ++++++++++++
 1 files changed

// File: rtl/reflet_int_ctrl.sv
// Interrupt controller: synchronises 8 sources, latches edges, routes enabled
// pending sources onto 4 prioritised request lines, and serves claim reads.
module reflet_int_ctrl #(
    parameter int wordsize = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          src,
    input  logic [2:0]          addr,
    input  logic [wordsize-1:0] data_in,
    input  logic                write_en,
    input  logic                read_en,
    output logic [wordsize-1:0] data_out,
    output logic [3:0]          ext_int
);

    logic [7:0]          s1_q, s2_q, s3_q;
    logic [7:0]          en_q, en_d;
    logic [7:0]          mode_q, mode_d;
    logic [15:0]         route_q, route_d;
    logic [7:0]          pend_q, pend_d;
    logic [wordsize-1:0] data_out_q, data_out_d;
    logic [3:0]          ext_q, ext_d;

    logic [7:0]       rise, eff, act, clr, pclr;
    logic [3:0]       clm_vld;
    logic [3:0][2:0]  clm_id;
    logic             clm_hit;
    logic [wordsize-1:0] rdata;

    assign rise = s2_q & ~s3_q;
    // Edge-mode sources use the latch, level-mode sources follow the synchronised input.
    assign eff  = (mode_q & pend_q) | (~mode_q & s2_q);
    assign act  = en_q & eff;

    always_comb begin
        for (int n = 0; n < 4; n++) begin
            clm_vld[n] = 1'b0;
            clm_id[n]  = 3'd0;
            for (int i = 7; i >= 0; i--) begin
                if (act[i] && route_q[2*i +: 2] == 2'(n)) begin
                    clm_vld[n] = 1'b1;
                    clm_id[n]  = 3'(i);
                end
            end
        end
    end

    assign ext_d   = clm_vld;
    assign clm_hit = read_en & addr[2] & clm_vld[addr[1:0]];
    assign clr     = clm_hit ? (8'b1 << clm_id[addr[1:0]]) : 8'h00;

    always_comb begin
        rdata = '0;
        case (addr)
            3'd0: rdata[7:0]  = en_q;
            3'd1: rdata[7:0]  = mode_q;
            3'd2: rdata[7:0]  = eff;
            3'd3: rdata[15:0] = route_q;
            default: begin
                if (clm_vld[addr[1:0]]) begin
                    rdata[wordsize-1] = 1'b1;
                    rdata[2:0]        = clm_id[addr[1:0]];
                end
            end
        endcase
    end

    always_comb begin
        en_d    = en_q;
        mode_d  = mode_q;
        route_d = route_q;
        pclr    = clr;
        if (write_en) begin
            case (addr)
                3'd0:    en_d    = data_in[7:0];
                3'd1:    mode_d  = data_in[7:0];
                3'd2:    pclr    = clr | data_in[7:0];
                3'd3:    route_d = data_in[15:0];
                default: ;
            endcase
        end
        // A fresh rise wins over any clear; leaving edge mode drops the latch.
        pend_d     = ((pend_q & ~pclr) | rise) & mode_d;
        data_out_d = read_en ? rdata : data_out_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q       <= '0;
            s2_q       <= '0;
            s3_q       <= '0;
            en_q       <= '0;
            mode_q     <= '0;
            route_q    <= '0;
            pend_q     <= '0;
            data_out_q <= '0;
            ext_q      <= '0;
        end else begin
            s1_q       <= src;
            s2_q       <= s1_q;
            s3_q       <= s2_q;
            en_q       <= en_d;
            mode_q     <= mode_d;
            route_q    <= route_d;
            pend_q     <= pend_d;
            data_out_q <= data_out_d;
            ext_q      <= ext_d;
        end
    end

    assign data_out = data_out_q;
    assign ext_int  = ext_q;

    if (wordsize > 16) begin : g_hi
        logic unused_hi;
        assign unused_hi = ^data_in[wordsize-1:16];
    end

endmodule
